// File: rtl/mac_dst_filter_if.sv
// RX word stream into the destination filter and its registered decision back out.
// master = MAC RX side (drives words, reads decision); slave = mac_dst_filter.
interface mac_dst_filter_if;
  logic [15:0] i_rx_data;
  logic [9:0]  i_wordNum;
  logic        i_data_valid;
  logic        i_recvDn;
  logic        o_recv_keep;
  logic        o_match_valid;
  logic [1:0]  o_match_type;
  logic [3:0]  o_mcast_idx;

  modport master (
    output i_rx_data, i_wordNum, i_data_valid, i_recvDn,
    input  o_recv_keep, o_match_valid, o_match_type, o_mcast_idx
  );

  modport slave (
    input  i_rx_data, i_wordNum, i_data_valid, i_recvDn,
    output o_recv_keep, o_match_valid, o_match_type, o_mcast_idx
  );
endinterface

// File: rtl/mac_dst_filter.sv
// Destination-MAC keep/drop filter: decision registered one edge after word 3, held until i_recvDn; no backpressure.
// Optional saturating drop counter when MAC_DST_FILTER_STATS_EN is defined.
module mac_dst_filter #(
  parameter int MCAST_N     = 4,
  parameter int MCAST_CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  mac_dst_filter_if.slave          rx,
  input  logic [47:0]              i_local_node_mac,
  input  logic [48*MCAST_N-1:0]    i_mcast_tbl,
  input  logic [MCAST_N-1:0]       i_mcast_en,
  input  logic                     i_bcast_en,
  input  logic                     i_promisc,
  input  logic                     i_cnt_clr,
  output logic [MCAST_CNT_W-1:0]   o_drop_cnt
);

  typedef enum logic [1:0] {IDLE, W2, W3, DONE} state_t;

  state_t             state;
  logic               uc_flag, bc_flag;
  logic [MCAST_N-1:0] mc_flag;

  logic               uc_eq, bc_eq;
  logic [MCAST_N-1:0] mc_eq;
  logic               uc_fin, bc_fin;
  logic [MCAST_N-1:0] mc_fin;
  logic [1:0]         nxt_type;
  logic [3:0]         nxt_idx;
  logic               nxt_keep;
  logic               dec_fire;

  // Address word for the current word index; word 1 carries the high 16 bits.
  function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [9:0] num);
    case (num)
      10'd2:   mac_word = mac[31:16];
      10'd3:   mac_word = mac[15:0];
      default: mac_word = mac[47:32];
    endcase
  endfunction

  always_comb begin
    uc_eq = (rx.i_rx_data == mac_word(i_local_node_mac, rx.i_wordNum));
    bc_eq = (rx.i_rx_data == 16'hFFFF);
    mc_eq = '0;
    for (int k = 0; k < MCAST_N; k++) begin
      mc_eq[k] = (rx.i_rx_data == mac_word(i_mcast_tbl[48*k +: 48], rx.i_wordNum));
    end
  end

  // Final classification, only consumed on the word-3 cycle.
  always_comb begin
    uc_fin   = uc_flag & uc_eq;
    bc_fin   = bc_flag & bc_eq & i_bcast_en;
    mc_fin   = mc_flag & mc_eq & i_mcast_en;
    nxt_type = 2'd0;
    nxt_idx  = 4'd0;
    for (int k = MCAST_N - 1; k >= 0; k--) begin
      if (mc_fin[k]) begin
        nxt_idx = 4'(k);
      end
    end
    if (bc_fin) begin
      nxt_type = 2'd2;
      nxt_idx  = 4'd0;
    end else if (uc_fin) begin
      nxt_type = 2'd1;
      nxt_idx  = 4'd0;
    end else if (|mc_fin) begin
      nxt_type = 2'd3;
    end
    nxt_keep = i_promisc | (nxt_type != 2'd0);
    dec_fire = (state == W3) && rx.i_data_valid && (rx.i_wordNum == 10'd3) && !rx.i_recvDn;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      uc_flag          <= 1'b0;
      bc_flag          <= 1'b0;
      mc_flag          <= '0;
      rx.o_recv_keep   <= 1'b1;
      rx.o_match_valid <= 1'b0;
      rx.o_match_type  <= 2'd0;
      rx.o_mcast_idx   <= 4'd0;
    end else if (rx.i_recvDn) begin
      state            <= IDLE;
      rx.o_recv_keep   <= 1'b1;
      rx.o_match_valid <= 1'b0;
      rx.o_match_type  <= 2'd0;
      rx.o_mcast_idx   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rx.i_data_valid && rx.i_wordNum == 10'd1) begin
            uc_flag <= uc_eq;
            bc_flag <= bc_eq;
            mc_flag <= mc_eq;
            state   <= W2;
          end
        end
        W2: begin
          if (rx.i_data_valid) begin
            if (rx.i_wordNum == 10'd2) begin
              uc_flag <= uc_flag & uc_eq;
              bc_flag <= bc_flag & bc_eq;
              mc_flag <= mc_flag & mc_eq;
              state   <= W3;
            end else if (rx.i_wordNum == 10'd1) begin
              uc_flag <= uc_eq;
              bc_flag <= bc_eq;
              mc_flag <= mc_eq;
            end else begin
              state <= IDLE;
            end
          end
        end
        W3: begin
          if (rx.i_data_valid) begin
            if (rx.i_wordNum == 10'd3) begin
              state            <= DONE;
              rx.o_recv_keep   <= nxt_keep;
              rx.o_match_valid <= 1'b1;
              rx.o_match_type  <= nxt_type;
              rx.o_mcast_idx   <= nxt_idx;
            end else if (rx.i_wordNum == 10'd1) begin
              uc_flag <= uc_eq;
              bc_flag <= bc_eq;
              mc_flag <= mc_eq;
              state   <= W2;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: ;  // DONE holds the decision until i_recvDn
      endcase
    end
  end

`ifdef MAC_DST_FILTER_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_drop_cnt <= '0;
    end else if (dec_fire && !nxt_keep && (o_drop_cnt != '1)) begin
      o_drop_cnt <= o_drop_cnt + MCAST_CNT_W'(1);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = i_cnt_clr | dec_fire;
  assign o_drop_cnt   = '0;
`endif

endmodule

// File: doc/mac_dst_filter.md
# mac_dst_filter

Parametrised receive-side destination-MAC filter for the MAC RX path. It captures the 48-bit destination address from the first three 16-bit receive words and matches it against the local node address, broadcast, and a table of MCAST_N multicast entries. It reports a registered keep/drop decision and a match class to the RX frame buffer. It supersedes the fixed always-keep address check and adds per-entry enables, promiscuous mode and an abort path.

## Interface
- MCAST_N, 4, number of multicast table entries (1..16)
- MCAST_CNT_W, 16, width of the optional drop counter
- i_clk  in  1  receive clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_rx_data  in  16  receive word, MSB byte first
- i_wordNum  in  10  index of the current word in the frame; 1..3 carry the destination MAC, high word first
- i_data_valid  in  1  i_rx_data/i_wordNum qualify this cycle
- i_recvDn  in  1  one-cycle end-of-frame (normal or aborted)
- i_local_node_mac  in  48  unicast address of this node
- i_mcast_tbl  in  48*MCAST_N  entry k at bits [48k+47:48k]
- i_mcast_en  in  MCAST_N  per-entry enable
- i_bcast_en  in  1  accept ff:ff:ff:ff:ff:ff
- i_promisc  in  1  keep every frame; classification still reported
- i_cnt_clr  in  1  synchronous clear of o_drop_cnt
- o_recv_keep  out  1  1 = keep frame; reset 1
- o_match_valid  out  1  decision valid for current frame; reset 0
- o_match_type  out  2  0 none, 1 unicast, 2 broadcast, 3 multicast; reset 0
- o_mcast_idx  out  4  lowest matching enabled entry index; reset 0
- o_drop_cnt  out  MCAST_CNT_W  dropped-frame count; reset 0

## Operation
- FSM states: IDLE, W2 (expect word 2), W3 (expect word 3), DONE.
- IDLE: a valid word with i_wordNum==1 loads the match flags and moves to W2. Other words are ignored.
- Per-word incremental compare; no full 48-bit register is needed.
  - Word 1: each flag is set to the 16-bit equality result.
  - Words 2 and 3: each flag is ANDed with the new equality result.
  - Flags cover unicast, broadcast, and each of the MCAST_N entries.
- W2 → W3 on a valid word 2. W3 → DONE on a valid word 3, and the decision is registered at that point.
- Out-of-sequence word in W2/W3:
  - word 1 restarts capture (reload flags, go to W2);
  - any other index aborts to IDLE with no decision.
- Classification priority: broadcast (only if i_bcast_en) > unicast > multicast (entry must be enabled; lowest index wins) > none.
- Keep rule: o_recv_keep = i_promisc | (type != 0). The value is latched at decision time.
- While no decision exists (IDLE/W2/W3), o_recv_keep=1 and o_match_valid=0.
- DONE: outputs are held until i_recvDn, then the FSM returns to IDLE with keep=1, valid=0, type=0, idx=0.
- i_recvDn has priority over a same-cycle data word; that word is ignored.
- i_recvDn before the decision: return to IDLE, no decision, no count.
- Configuration inputs are sampled on each word cycle. Changes mid-frame affect only words not yet compared.

## Timing
- Decision latency: outputs update on the clock edge after the cycle word 3 is accepted. The earliest o_match_valid=1 is the first cycle with i_wordNum>=4.
- o_match_valid, o_recv_keep, o_match_type and o_mcast_idx change together and are glitch-free (registered).
- Asynchronous reset at any point returns to IDLE with all outputs at their reset values, even mid-frame.
- i_cnt_clr takes effect next edge. If it coincides with a drop, the clear wins.

## Configuration
- MAC_DST_FILTER_STATS_EN defined:
  - o_drop_cnt increments by 1 on each decision with o_recv_keep=0.
  - It saturates at all-ones and does not wrap.
  - It is cleared by i_cnt_clr.
- Not defined: the counter logic is omitted. o_drop_cnt is tied to 0 and i_cnt_clr is ignored. Ports remain for integration stability.

## Test plan
- Local MAC 00:11:22:33:44:55 sent as words 0x0011,0x2233,0x4455 → keep=1, type=1, valid=1 one edge after word 3; after i_recvDn, valid=0 and keep=1.
- Broadcast frame:
  - with i_bcast_en=1 → type=2, keep=1;
  - with i_bcast_en=0 and no promisc → type=0, keep=0, drop_cnt 0→1 (stats build).
- Table entries 1 and 3 both 01:00:5e:00:01:81 and enabled → type=3, idx=1. Disable entry 1 → idx=3. Disable both → keep=0.
- Unknown unicast 02:00:00:00:00:09:
  - with i_promisc=1 → keep=1, type=0, drop_cnt unchanged;
  - i_recvDn asserted after word 2 → no valid, state IDLE, counter unchanged.
- Sequence faults:
  - word 1, word 1, word 2, word 3 → decision uses the second word 1;
  - word 1 then word 3 → abort, no decision;
  - i_rst_n pulsed in W3 → all outputs reset.
- Stats build: force 0xFFFF drops → counter holds 0xFFFF. i_cnt_clr coinciding with a drop → counter 0.
